// File: rtl/rsp_prep_pkg.sv
// Shared constants and types for the s1 prep difference / integration stages.
// Combinational definitions only; no latency and no flow control.
package rsp_prep_pkg;

  localparam int LANE_W = 16;
  localparam int ACC_W  = 24;

  localparam logic [LANE_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [LANE_W-1:0] SAT_MIN = 16'h8001;

  typedef logic signed [LANE_W-1:0] lane_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam logic MODE_LAG1 = 1'b1;
  localparam logic MODE_LAG2 = 1'b0;

endpackage

// File: rtl/rsp_sat_trunc.sv
// Symmetric saturator from IN_W to OUT_W: clamps to +/-(2^(OUT_W-1)-1), so the most negative code never appears.
// Purely combinational, zero latency, no backpressure.
module rsp_sat_trunc
  import rsp_prep_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = LANE_W
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] HI = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] LO = -HI;

  always_comb begin
    if (din > HI) begin
      dout = HI[OUT_W-1:0];
    end else if (din < LO) begin
      dout = LO[OUT_W-1:0];
    end else begin
      dout = din[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/rsp_s1_prep_integ.sv
// Rebuilds raw samples from lag-1/lag-2 difference bursts via a per-frame running sum, saturated to LANE width.
// Fixed 3-cycle latency (prefix, carry add, saturate); no backpressure, one beat accepted per cycle.
module rsp_s1_prep_integ
  import rsp_prep_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 32,
  parameter int DATA_NUM     = 1024,
  parameter int BURST_LEN    = 8,
  parameter int ACC_WIDTH    = 24
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_switch,
  input  logic [BURST_LEN-1:0][SAMPLE_WIDTH/2-1:0]  i_x0_data,
  input  logic                                      i_x0_valid,
  input  logic                                      i_x0_last,
  output logic [BURST_LEN-1:0][SAMPLE_WIDTH/2-1:0]  o_y0,
  output logic                                      o_y0_valid,
  output logic                                      o_y0_last
);

  localparam int LW    = SAMPLE_WIDTH / 2;
  localparam int BEATS = DATA_NUM / BURST_LEN;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] TERM = CW'(BEATS - 1);

  typedef logic [BURST_LEN-1:0][ACC_WIDTH-1:0] acc_vec_t;

  // Burst-local prefix sums; lag-2 keeps even and odd lanes on separate chains.
  function automatic acc_vec_t prefix(input logic [BURST_LEN-1:0][LW-1:0] d, input logic lag1);
    acc_vec_t             p;
    logic [ACC_WIDTH-1:0] e;
    p = '0;
    for (int k = 0; k < BURST_LEN; k++) begin
      e = {{(ACC_WIDTH-LW){d[k][LW-1]}}, d[k]};
      if (k == 0)       p[k] = e;
      else if (lag1)    p[k] = p[k-1] + e;
      else if (k == 1)  p[k] = e;
      else              p[k] = p[k-2] + e;
    end
    return p;
  endfunction

  logic [CW-1:0] beat_cnt;
  logic          mode_q;
  logic          first;
  logic          cur_mode;

  assign first    = (beat_cnt == '0);
  assign cur_mode = first ? i_switch : mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      mode_q   <= MODE_LAG2;
    end else if (i_x0_valid) begin
      if (first) mode_q <= i_switch;
      if (i_x0_last || beat_cnt == TERM) beat_cnt <= '0;
      else                               beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // S1: register burst-local prefix sums with the frame context they need.
  logic     s1_vld, s1_last, s1_first, s1_mode;
  acc_vec_t s1_pre;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_mode  <= MODE_LAG2;
      s1_pre   <= '0;
    end else begin
      s1_vld  <= i_x0_valid;
      s1_last <= i_x0_valid && i_x0_last;
      if (i_x0_valid) begin
        s1_pre   <= prefix(i_x0_data, cur_mode == MODE_LAG1);
        s1_first <= first;
        s1_mode  <= cur_mode;
      end
    end
  end

  // S2: add carries from the previous beat of the same frame.
  logic [ACC_WIDTH-1:0] carry1, carry_e, carry_o;
  acc_vec_t             s2_nxt, s2_sum;
  logic                 s2_vld, s2_last;

  always_comb begin
    logic [ACC_WIDTH-1:0] base;
    base   = '0;
    s2_nxt = '0;
    for (int k = 0; k < BURST_LEN; k++) begin
      if (s1_first)                base = '0;
      else if (s1_mode == MODE_LAG1) base = carry1;
      else if (k % 2 == 0)         base = carry_e;
      else                         base = carry_o;
      s2_nxt[k] = s1_pre[k] + base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_sum  <= '0;
      carry1  <= '0;
      carry_e <= '0;
      carry_o <= '0;
    end else begin
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      if (s1_vld) begin
        s2_sum  <= s2_nxt;
        carry1  <= s2_nxt[BURST_LEN-1];
        carry_e <= s2_nxt[BURST_LEN-2];
        carry_o <= s2_nxt[BURST_LEN-1];
      end
    end
  end

  // S3: saturate each lane; output data holds across bubbles.
  logic [BURST_LEN-1:0][LW-1:0] sat_out;

  for (genvar g = 0; g < BURST_LEN; g++) begin : g_sat
    rsp_sat_trunc #(.IN_W(ACC_WIDTH), .OUT_W(LW)) u_sat (
      .din  (s2_sum[g]),
      .dout (sat_out[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_y0       <= '0;
      o_y0_valid <= 1'b0;
      o_y0_last  <= 1'b0;
    end else begin
      o_y0_valid <= s2_vld;
      o_y0_last  <= s2_last;
      if (s2_vld) o_y0 <= sat_out;
    end
  end

endmodule

// File: tb/tb_rsp_s1_prep_integ.sv
// Scoreboard bench: a sample-level recurrence model predicts each output beat; a monitor pops and compares.
module tb_rsp_s1_prep_integ;
  import rsp_prep_pkg::*;

  localparam int BL    = 8;
  localparam int BEATS = 1024 / BL;

  typedef logic [BL-1:0][LANE_W-1:0] vec_t;
  typedef struct {
    vec_t dat;
    logic last;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_switch = 1'b0;
  logic i_x0_valid = 1'b0;
  logic i_x0_last = 1'b0;
  vec_t i_x0_data = '0;
  vec_t o_y0;
  logic o_y0_valid, o_y0_last;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t last_out = '0;

  // Reference model state: samples of the current frame and beats seen in it.
  int   m_fb = 0;
  logic m_mode = MODE_LAG2;
  int   hist[$];

  rsp_s1_prep_integ dut (
    .clk        (clk),
    .rst        (rst),
    .i_switch   (i_switch),
    .i_x0_data  (i_x0_data),
    .i_x0_valid (i_x0_valid),
    .i_x0_last  (i_x0_last),
    .o_y0       (o_y0),
    .o_y0_valid (o_y0_valid),
    .o_y0_last  (o_y0_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic int wrap_acc(input int v);
    return (v <<< (32 - ACC_W)) >>> (32 - ACC_W);
  endfunction

  function automatic logic [LANE_W-1:0] sat(input int v);
    int lim;
    lim = (1 <<< (LANE_W - 1)) - 1;
    if (v > lim)  return SAT_MAX;
    if (v < -lim) return SAT_MIN;
    return v[LANE_W-1:0];
  endfunction

  function automatic vec_t fill(input int v);
    vec_t r;
    for (int k = 0; k < BL; k++) r[k] = LANE_W'(v);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // y[n] = y[n-lag] + d[n] over the frame's sample sequence, wrapped at ACC_W.
  task automatic send(input vec_t d, input logic sw, input logic last);
    exp_t e;
    int   lag, n, prev, v;
    if (m_fb == 0) begin
      m_mode = sw;
      hist.delete();
    end
    lag = (m_mode == MODE_LAG1) ? 1 : 2;
    for (int k = 0; k < BL; k++) begin
      n    = hist.size();
      prev = (n >= lag) ? hist[n-lag] : 0;
      v    = wrap_acc(prev + int'($signed(d[k])));
      hist.push_back(v);
      e.dat[k] = sat(v);
    end
    e.last = last;
    e.cyc  = cyc + 3;
    exp_q.push_back(e);
    m_fb++;
    if (last || m_fb == BEATS) m_fb = 0;
    i_x0_data  = d;
    i_switch   = sw;
    i_x0_last  = last;
    i_x0_valid = 1'b1;
    @(posedge clk);
    #1;
    i_x0_valid = 1'b0;
    i_x0_last  = 1'b0;
    i_switch   = 1'($urandom);
    i_x0_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_out = '0;
    end else if (o_y0_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_valid: got beat %h expected no beat", o_y0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("y0", o_y0, mon_e.dat);
        chk("y0_last", o_y0_last, mon_e.last);
        chk("latency_cycle", cyc, mon_e.cyc);
      end
      last_out = o_y0;
    end else begin
      chk("hold_y0", o_y0, last_out);
      chk("idle_last", o_y0_last, 1'b0);
    end
  end

  initial begin
    vec_t d;
    int   len, gap, sw;
    logic big;

    idle(3);
    rst = 1'b0;
    chk("rst_y0", o_y0, '0);
    chk("rst_valid", o_y0_valid, 1'b0);
    chk("rst_last", o_y0_last, 1'b0);

    // Lag-1 ramp, then lag-2 interleave.
    send(fill(1), MODE_LAG1, 1'b0);
    send(fill(1), MODE_LAG1, 1'b1);
    idle(4);
    d = fill(1);
    d[0] = 16'd5;
    d[1] = 16'd7;
    send(d, MODE_LAG2, 1'b0);
    send(fill(2), MODE_LAG1, 1'b1);
    idle(4);

    // Full frame with last on the terminal beat, then a fresh frame.
    for (int b = 0; b < BEATS; b++) send(fill(1), MODE_LAG1, b == BEATS - 1);
    send(fill(1), MODE_LAG1, 1'b1);
    idle(4);

    // Saturation in both directions, exact recovery from the internal sum.
    send(fill(16'h4000), MODE_LAG1, 1'b1);
    send(fill(16'hC000), MODE_LAG1, 1'b0);
    send(fill(16'h4000), MODE_LAG1, 1'b1);
    send(fill(16'h4000), MODE_LAG1, 1'b0);
    send(fill(16'hC000), MODE_LAG1, 1'b1);
    idle(4);

    // Bubbles with i_switch toggling mid-frame.
    for (int b = 0; b < 6; b++) begin
      send(fill(1), (b == 0) ? MODE_LAG1 : 1'(b), b == 5);
      idle(2);
    end
    idle(4);

    // Reset mid-frame discards in-flight beats.
    for (int b = 0; b < 3; b++) send(fill(1), MODE_LAG1, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    hist.delete();
    m_fb = 0;
    idle(1);
    rst = 1'b0;
    chk("midrst_valid", o_y0_valid, 1'b0);
    send(fill(1), MODE_LAG1, 1'b1);
    idle(4);

    // Terminal count wraps the frame without last.
    for (int b = 0; b < BEATS; b++) begin
      for (int k = 0; k < BL; k++) d[k] = LANE_W'($urandom_range(0, 40) - 20);
      send(d, MODE_LAG2, 1'b0);
    end
    send(fill(1), MODE_LAG1, 1'b1);
    idle(4);

    // Random frames: lengths, gaps, modes, small or full-range data.
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 12);
      sw  = $urandom_range(0, 1);
      big = 1'($urandom);
      for (int b = 0; b < len; b++) begin
        for (int k = 0; k < BL; k++)
          d[k] = big ? LANE_W'($urandom) : LANE_W'($urandom_range(0, 100) - 50);
        send(d, (b == 0) ? 1'(sw) : 1'($urandom), b == len - 1);
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        idle(gap);
      end
    end

    idle(8);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
